spi_job_io: RTL and testbench
=============================

SPI_JOB_IO -- requirements
Module: spi_job_io

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- JOB_CONFIG_WIDTH, 8, job config bits loaded via SPI0
- DEVICE_CONFIG_WIDTH, 8, device config bits loaded via SPI1
- RESULT_DATA_WIDTH, 16, result bits read out via SPI1
- SYNC_STAGES, 2, synchroniser depth on all pin inputs (>=2)
REQ-002 Ports SHALL be (name direction width meaning), one per line:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sck0  in  1  SPI0 clock
- sdi0  in  1  SPI0 data in
- cs0_n  in  1  SPI0 select, active-low
- sck1  in  1  SPI1 clock
- sdi1  in  1  SPI1 data in
- sdo1  out  1  SPI1 data out
- cs1_n  in  1  SPI1 select, active-low
- job_config  out  JOB_CONFIG_WIDTH  committed job config
- job_config_valid  out  1  one-cycle commit pulse
- device_config  out  DEVICE_CONFIG_WIDTH  committed device config
- device_config_valid  out  1  one-cycle commit pulse
- frame_error  out  1  one-cycle bad-frame pulse, either port
- shapool_result  in  RESULT_DATA_WIDTH  result from core
- shapool_success  in  1  core success level
- ready  out  1  result latched, awaiting readout
REQ-003 One clock (clk); reset synchronous, active-high; all state updates on rising clk only.

Function
REQ-004 sck*, sdi*, cs*_n SHALL each pass through SYNC_STAGES flops; all edge detection on synchroniser outputs.
REQ-005 SPI mode 0 only: sample sdi on synchronised sck rise, change sdo1 on synchronised sck fall, MSB first.
REQ-006 Each port SHALL track in_frame: set on synchronised cs_n fall, cleared on cs_n rise; sck edges outside a frame ignored.
REQ-007 On sck rise in frame: shift sdi into port shift register LSB, increment bit counter (saturating, width clog2(max width)+2).
REQ-008 Counter and shift register cleared on cs_n fall.
REQ-009 SPI0 on cs0_n rise: count == JOB_CONFIG_WIDTH -> job_config <= shift reg, job_config_valid pulses 1 cycle; otherwise frame_error pulses, job_config unchanged.
REQ-010 SPI1 config frame (ready=0 at cs1_n fall): daisy-chain; sdo1 drives current shift-register MSB, updated on each sck fall; on cs1_n rise count >= DEVICE_CONFIG_WIDTH -> device_config <= last DEVICE_CONFIG_WIDTH bits, device_config_valid pulses; count < width -> frame_error.
REQ-011 Result latch: on rising edge of registered shapool_success while ready=0, result register <= shapool_result, ready <= 1; success edges while ready=1 ignored (first result kept).
REQ-012 SPI1 readout frame (ready=1 at cs1_n fall): sdo1 = result MSB from frame start, shifts one bit per sck fall; after RESULT_DATA_WIDTH bits sdo1 = 0; sdi1 ignored; device_config untouched.
REQ-013 Readout cs1_n rise: count >= RESULT_DATA_WIDTH -> ready <= 0; else ready held, frame_error pulses.
REQ-014 sdo1 = 0 whenever cs1_n (synchronised) high.
REQ-015 Same-cycle cs_n rise and sck rise: cs_n rise wins, sck edge discarded.
REQ-016 Valid/error pulse SHALL assert the cycle after synchronised cs_n rise is detected; never two consecutive cycles per frame.

Reset
REQ-017 reset=1: job_config=0, device_config=0, all valid/error pulses 0, ready=0, sdo1=0, result register 0, in_frame=0, counters 0, synchronisers idle (cs_n=1, sck=0, sdi=0).
REQ-018 Reset mid-frame SHALL discard the frame; a cs_n rise after reset without a prior cs_n fall produces no commit and no error.
REQ-019 shapool_success high during reset SHALL NOT latch; level still high after reset counts as a rising edge once.

Verification
REQ-020 SPI0 8 bits 0xAA, cs0_n rise -> job_config=0xAA, one job_config_valid pulse, no frame_error.
REQ-021 SPI0 7 bits then cs0_n rise -> frame_error pulse, job_config keeps prior value.
REQ-022 SPI1 16 bits 0x55AA (chain of two) -> device_config=0xAA, sdo1 emits 0x55 on bits 9-16.
REQ-023 shapool_result=0x4141, success pulse, SPI1 16-bit read -> sdo1 stream 0x4141, ready 1 -> 0 after cs1_n rise; device_config unchanged.
REQ-024 Second success with result 0x1234 while ready=1 -> readout still 0x4141; 8-bit readout -> frame_error, ready stays 1.
REQ-025 Reset asserted after 4 SPI0 bits, then cs0_n rise -> no valid, no error, job_config=0.

Source files
------------

// File: rtl/spi_job_io.sv
// Two SPI mode-0 slave ports: SPI0 loads job config, SPI1 daisy-chains device config or reads out the latched core result.
// Commit/error pulses land one clk after the synchronised cs_n rise; no backpressure, the SPI master paces every frame.
module spi_job_io #(
  parameter int JOB_CONFIG_WIDTH    = 8,
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int RESULT_DATA_WIDTH   = 16,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sck0,
  input  logic                           sdi0,
  input  logic                           cs0_n,
  input  logic                           sck1,
  input  logic                           sdi1,
  output logic                           sdo1,
  input  logic                           cs1_n,
  output logic [JOB_CONFIG_WIDTH-1:0]    job_config,
  output logic                           job_config_valid,
  output logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
  output logic                           device_config_valid,
  output logic                           frame_error,
  input  logic [RESULT_DATA_WIDTH-1:0]   shapool_result,
  input  logic                           shapool_success,
  output logic                           ready
);
  localparam int JW = JOB_CONFIG_WIDTH;
  localparam int DW = DEVICE_CONFIG_WIDTH;
  localparam int RW = RESULT_DATA_WIDTH;
  localparam int MAX_W = (JW > DW) ? ((JW > RW) ? JW : RW) : ((DW > RW) ? DW : RW);
  localparam int CNT_W = $clog2(MAX_W) + 2;
  localparam int SETTLE_MAX = SYNC_STAGES + 1;
  localparam int SETTLE_W = $clog2(SETTLE_MAX + 1);

  logic [SYNC_STAGES-1:0] sck0_sync, sdi0_sync, cs0_sync, sck1_sync, sdi1_sync, cs1_sync;
  logic sck0_s, sdi0_s, cs0_s, sck1_s, sdi1_s, cs1_s;
  logic sck0_d, cs0_d, sck1_d, cs1_d;
  logic [SETTLE_W-1:0] settle_cnt;
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck0_sync  <= '0;
      sdi0_sync  <= '0;
      cs0_sync   <= '1;
      sck1_sync  <= '0;
      sdi1_sync  <= '0;
      cs1_sync   <= '1;
      sck0_d     <= 1'b0;
      cs0_d      <= 1'b1;
      sck1_d     <= 1'b0;
      cs1_d      <= 1'b1;
      settle_cnt <= '0;
    end else begin
      sck0_sync <= {sck0_sync[SYNC_STAGES-2:0], sck0};
      sdi0_sync <= {sdi0_sync[SYNC_STAGES-2:0], sdi0};
      cs0_sync  <= {cs0_sync[SYNC_STAGES-2:0], cs0_n};
      sck1_sync <= {sck1_sync[SYNC_STAGES-2:0], sck1};
      sdi1_sync <= {sdi1_sync[SYNC_STAGES-2:0], sdi1};
      cs1_sync  <= {cs1_sync[SYNC_STAGES-2:0], cs1_n};
      sck0_d    <= sck0_s;
      cs0_d     <= cs0_s;
      sck1_d    <= sck1_s;
      cs1_d     <= cs1_s;
      if (!armed) settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

  assign sck0_s = sck0_sync[SYNC_STAGES-1];
  assign sdi0_s = sdi0_sync[SYNC_STAGES-1];
  assign cs0_s  = cs0_sync[SYNC_STAGES-1];
  assign sck1_s = sck1_sync[SYNC_STAGES-1];
  assign sdi1_s = sdi1_sync[SYNC_STAGES-1];
  assign cs1_s  = cs1_sync[SYNC_STAGES-1];

  // Edges are blanked until the synchronisers hold real pin samples, so a cs_n
  // still low from before reset cannot fake a frame start.
  assign armed = (settle_cnt == SETTLE_W'(SETTLE_MAX));

  logic sck0_rise, cs0_fall, cs0_rise;
  logic sck1_rise, sck1_fall, cs1_fall, cs1_rise;
  assign sck0_rise = armed & sck0_s & ~sck0_d;
  assign cs0_fall  = armed & cs0_d & ~cs0_s;
  assign cs0_rise  = armed & ~cs0_d & cs0_s;
  assign sck1_rise = armed & sck1_s & ~sck1_d;
  assign sck1_fall = armed & ~sck1_s & sck1_d;
  assign cs1_fall  = armed & cs1_d & ~cs1_s;
  assign cs1_rise  = armed & ~cs1_d & cs1_s;

  logic          in_frame0, err0;
  logic [CNT_W-1:0] cnt0;
  logic [JW-1:0] sr0;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame0        <= 1'b0;
      cnt0             <= '0;
      sr0              <= '0;
      job_config       <= '0;
      job_config_valid <= 1'b0;
      err0             <= 1'b0;
    end else begin
      job_config_valid <= 1'b0;
      err0             <= 1'b0;
      if (cs0_fall) begin
        in_frame0 <= 1'b1;
        cnt0      <= '0;
        sr0       <= '0;
      end else if (cs0_rise) begin
        in_frame0 <= 1'b0;
        if (in_frame0) begin
          if (cnt0 == CNT_W'(JW)) begin
            job_config       <= sr0;
            job_config_valid <= 1'b1;
          end else begin
            err0 <= 1'b1;
          end
        end
      end else if (sck0_rise && in_frame0) begin
        sr0 <= {sr0[JW-2:0], sdi0_s};
        if (cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
      end
    end
  end

  logic          in_frame1, err1, rd_mode, sdo_q, succ_q, succ_d;
  logic [CNT_W-1:0] cnt1;
  logic [DW-1:0] sr1;
  logic [RW-1:0] rd_sr, result;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame1           <= 1'b0;
      cnt1                <= '0;
      sr1                 <= '0;
      rd_sr               <= '0;
      rd_mode             <= 1'b0;
      sdo_q               <= 1'b0;
      device_config       <= '0;
      device_config_valid <= 1'b0;
      err1                <= 1'b0;
      ready               <= 1'b0;
      result              <= '0;
      succ_q              <= 1'b0;
      succ_d              <= 1'b0;
    end else begin
      device_config_valid <= 1'b0;
      err1                <= 1'b0;
      succ_q              <= shapool_success;
      succ_d              <= succ_q;
      if (succ_q && !succ_d && !ready) begin
        result <= shapool_result;
        ready  <= 1'b1;
      end
      // Frame type is fixed by ready at the cs1_n fall for the whole frame.
      if (cs1_fall) begin
        in_frame1 <= 1'b1;
        cnt1      <= '0;
        sr1       <= '0;
        rd_mode   <= ready;
        rd_sr     <= result;
        sdo_q     <= ready & result[RW-1];
      end else if (cs1_rise) begin
        in_frame1 <= 1'b0;
        sdo_q     <= 1'b0;
        if (in_frame1) begin
          if (rd_mode) begin
            if (cnt1 >= CNT_W'(RW)) ready <= 1'b0;
            else                    err1  <= 1'b1;
          end else if (cnt1 >= CNT_W'(DW)) begin
            device_config       <= sr1;
            device_config_valid <= 1'b1;
          end else begin
            err1 <= 1'b1;
          end
        end
      end else if (in_frame1) begin
        if (sck1_rise) begin
          if (!rd_mode) sr1 <= {sr1[DW-2:0], sdi1_s};
          if (cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
        end
        if (sck1_fall) begin
          if (rd_mode) begin
            sdo_q <= rd_sr[RW-2];
            rd_sr <= {rd_sr[RW-2:0], 1'b0};
          end else begin
            sdo_q <= sr1[DW-1];
          end
        end
      end
    end
  end

  assign sdo1        = sdo_q & ~cs1_s;
  assign frame_error = err0 | err1;
endmodule

// File: tb/tb_spi_job_io.sv
// Bench for spi_job_io: table of SPI frames plus hand sequences for readout, collision and reset corners.
// Commit/error pulses are checked against a scoreboard queue filled before each frame.
module tb_spi_job_io;
  localparam int HP = 6;
  localparam int EV_JOB = 0;
  localparam int EV_DEV = 1;
  localparam int EV_ERR = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck0 = 1'b0, sdi0 = 1'b0, cs0_n = 1'b1;
  logic sck1 = 1'b0, sdi1 = 1'b0, cs1_n = 1'b1;
  logic sdo1;
  logic [7:0] job_config, device_config;
  logic job_config_valid, device_config_valid, frame_error, ready;
  logic [15:0] shapool_result = '0;
  logic shapool_success = 1'b0;

  spi_job_io dut (
    .clk(clk), .reset(reset),
    .sck0(sck0), .sdi0(sdi0), .cs0_n(cs0_n),
    .sck1(sck1), .sdi1(sdi1), .sdo1(sdo1), .cs1_n(cs1_n),
    .job_config(job_config), .job_config_valid(job_config_valid),
    .device_config(device_config), .device_config_valid(device_config_valid),
    .frame_error(frame_error),
    .shapool_result(shapool_result), .shapool_success(shapool_success),
    .ready(ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    bit          port;
    int          nbits;
    logic [31:0] data;
    bit          exp_err;
    logic [15:0] exp_cfg;
    logic [15:0] exp_dout;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [15:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_pulse: got pulse kind %0d value %0h, required none", kind, val);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", kind, e.kind);
      chk("sb_val", val, e.val);
    end
  endtask

  logic prev_any = 1'b0;
  always @(negedge clk) begin
    if (job_config_valid)    sb_pop(EV_JOB, {8'h00, job_config});
    if (device_config_valid) sb_pop(EV_DEV, {8'h00, device_config});
    if (frame_error)         sb_pop(EV_ERR, 16'h0);
    if (job_config_valid | device_config_valid | frame_error)
      chk("pulse_single_cycle", prev_any, 0);
    prev_any = job_config_valid | device_config_valid | frame_error;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi0_xfer(input logic [31:0] din, input int nbits);
    cs0_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < nbits; i++) begin
      sdi0 = din[nbits-1-i];
      wait_clk(HP);
      sck0 = 1'b1;
      wait_clk(HP);
      sck0 = 1'b0;
    end
    wait_clk(HP);
    cs0_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic spi1_xfer(input logic [31:0] din, input int nbits, output logic [31:0] dout);
    dout = '0;
    cs1_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < nbits; i++) begin
      sdi1 = din[nbits-1-i];
      wait_clk(HP);
      dout = {dout[30:0], sdo1};
      sck1 = 1'b1;
      wait_clk(HP);
      sck1 = 1'b0;
    end
    wait_clk(HP);
    cs1_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic success_pulse(input logic [15:0] res);
    shapool_result = res;
    shapool_success = 1'b1;
    wait_clk(3);
    shapool_success = 1'b0;
    wait_clk(5);
  endtask

  initial begin
    logic [31:0] dout;

    vt[0] = '{port: 1'b0, nbits: 8,  data: 32'hAA,   exp_err: 1'b0, exp_cfg: 16'hAA, exp_dout: 16'h0};
    vt[1] = '{port: 1'b0, nbits: 7,  data: 32'h55,   exp_err: 1'b1, exp_cfg: 16'hAA, exp_dout: 16'h0};
    vt[2] = '{port: 1'b0, nbits: 8,  data: 32'h3C,   exp_err: 1'b0, exp_cfg: 16'h3C, exp_dout: 16'h0};
    vt[3] = '{port: 1'b1, nbits: 16, data: 32'h55AA, exp_err: 1'b0, exp_cfg: 16'hAA, exp_dout: 16'h0055};
    vt[4] = '{port: 1'b1, nbits: 7,  data: 32'h7F,   exp_err: 1'b1, exp_cfg: 16'hAA, exp_dout: 16'h0};
    vt[5] = '{port: 1'b1, nbits: 8,  data: 32'hC3,   exp_err: 1'b0, exp_cfg: 16'hC3, exp_dout: 16'h0};
    vt[6] = '{port: 1'b0, nbits: 9,  data: 32'h1FF,  exp_err: 1'b1, exp_cfg: 16'h3C, exp_dout: 16'h0};
    vt[7] = '{port: 1'b1, nbits: 10, data: 32'h2F0,  exp_err: 1'b0, exp_cfg: 16'hF0, exp_dout: 16'h0002};

    wait_clk(5);
    chk("rst_job_config", job_config, 0);
    chk("rst_device_config", device_config, 0);
    chk("rst_ready", ready, 0);
    chk("rst_sdo1", sdo1, 0);
    chk("rst_pulses", {job_config_valid, device_config_valid, frame_error}, 0);
    reset = 1'b0;
    wait_clk(8);

    for (int i = 0; i < 8; i++) begin
      if (vt[i].exp_err) push(EV_ERR, 16'h0);
      else               push(vt[i].port ? EV_DEV : EV_JOB, vt[i].exp_cfg);
      if (vt[i].port == 1'b0) begin
        spi0_xfer(vt[i].data, vt[i].nbits);
        chk($sformatf("vec%0d_job_config", i), job_config, vt[i].exp_cfg);
      end else begin
        spi1_xfer(vt[i].data, vt[i].nbits, dout);
        chk($sformatf("vec%0d_device_config", i), device_config, vt[i].exp_cfg);
        chk($sformatf("vec%0d_sdo1_stream", i), dout, vt[i].exp_dout);
      end
      chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
    end

    // Result latch then full readout
    success_pulse(16'h4141);
    chk("rd1_ready_set", ready, 1);
    spi1_xfer(32'hFFFF, 16, dout);
    chk("rd1_stream", dout, 32'h4141);
    chk("rd1_ready_clear", ready, 0);
    chk("rd1_device_config_kept", device_config, 8'hF0);
    chk("rd1_sb_empty", sb.size(), 0);

    // First result kept; short readout is an error and keeps ready
    success_pulse(16'h4141);
    chk("rd2_ready_set", ready, 1);
    success_pulse(16'h1234);
    push(EV_ERR, 16'h0);
    spi1_xfer(32'h0, 8, dout);
    chk("rd2_short_stream", dout, 32'h41);
    chk("rd2_ready_held", ready, 1);
    spi1_xfer(32'h0, 16, dout);
    chk("rd2_full_stream", dout, 32'h4141);
    chk("rd2_ready_clear", ready, 0);
    chk("rd2_device_config_kept", device_config, 8'hF0);
    chk("rd2_sb_empty", sb.size(), 0);

    // cs0_n rise coincident with the 8th sck rise: the edge is dropped, frame is 7 bits
    push(EV_ERR, 16'h0);
    cs0_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < 8; i++) begin
      sdi0 = 1'b1;
      wait_clk(HP);
      sck0 = 1'b1;
      if (i == 7) cs0_n = 1'b1;
      wait_clk(HP);
      sck0 = 1'b0;
    end
    wait_clk(12);
    chk("coll_job_config", job_config, 8'h3C);
    chk("coll_sb_empty", sb.size(), 0);

    // Reset in the middle of an SPI0 frame
    cs0_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < 4; i++) begin
      sdi0 = 1'b1;
      wait_clk(HP);
      sck0 = 1'b1;
      wait_clk(HP);
      sck0 = 1'b0;
    end
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(10);
    cs0_n = 1'b1;
    wait_clk(12);
    chk("midrst_job_config", job_config, 0);
    chk("midrst_device_config", device_config, 0);
    chk("midrst_sb_empty", sb.size(), 0);

    // Success held high across reset latches exactly once afterwards
    shapool_result = 16'hBEEF;
    shapool_success = 1'b1;
    reset = 1'b1;
    wait_clk(5);
    chk("succ_rst_no_latch", ready, 0);
    reset = 1'b0;
    wait_clk(6);
    chk("succ_after_rst_latch", ready, 1);
    spi1_xfer(32'h0, 16, dout);
    chk("succ_rst_stream", dout, 32'hBEEF);
    chk("succ_rst_ready_clear", ready, 0);
    wait_clk(10);
    chk("succ_level_no_relatch", ready, 0);
    shapool_success = 1'b0;
    wait_clk(5);

    chk("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
